// File: rtl/kitt_pkg.sv
// kitt_pkg: constants and helpers shared by the KITT scanner and its afterglow fader.
package kitt_pkg;
    localparam int CLK_FREQ   = 12_000_000;
    localparam int LEVEL_BITS = 4;
    localparam int LEVEL_MAX  = 15;
    localparam int LED_COUNT  = 8;

    typedef logic [LEVEL_BITS-1:0] level_t;

    localparam level_t LVL_MAX = level_t'(LEVEL_MAX);

    // Saturating subtract so a fading LED parks at dark instead of wrapping to bright.
    function automatic level_t sat_sub(input level_t a, input level_t b);
        return (a > b) ? level_t'(a - b) : '0;
    endfunction
endpackage

// File: rtl/kitt_fader_chan.sv
// kitt_fader_chan: one LED's brightness level (load/decay) and its registered PWM drive.
module kitt_fader_chan
    import kitt_pkg::*;
#(
    parameter int DECAY_STEP = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   fade_en,
    input  logic   pat,
    input  logic   decay_tick,
    input  level_t pwm_cnt,
    output logic   led
);
    localparam level_t STEP = level_t'(DECAY_STEP);

    level_t level;
    level_t level_nxt;
    logic   led_nxt;

    // A scanner hit reloads full brightness even on a decay tick.
    always_comb begin
        level_nxt = pat ? LVL_MAX : decay_tick ? sat_sub(level, STEP) : level;
        led_nxt   = fade_en ? (level == LVL_MAX || level > pwm_cnt) : pat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= '0;
            led   <= 1'b0;
        end else begin
            level <= level_nxt;
            led   <= led_nxt;
        end
    end
endmodule

// File: rtl/kitt_fader.sv
// kitt_fader: afterglow fader for an 8-LED scanner; shared decay/PWM timebase plus one channel per LED.
module kitt_fader
    import kitt_pkg::*;
#(
    parameter int CLK_FREQ     = kitt_pkg::CLK_FREQ,
    parameter int DECAY_MS     = 25,
    parameter int DECAY_CYCLES = (CLK_FREQ / 1000) * DECAY_MS,
    parameter int PWM_PRESCALE = 64,
    parameter int DECAY_STEP   = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 FADE_EN,
    input  logic [LED_COUNT-1:0] PAT_IN,
    output logic [LED_COUNT-1:0] LED_OUT
);
    localparam int DW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

    logic [DW-1:0] decay_cnt;
    logic [PW-1:0] pre;
    level_t        pwm_cnt;
    logic          decay_tick;
    logic          pwm_tick;

    assign decay_tick = decay_cnt == DW'(DECAY_CYCLES - 1);
    assign pwm_tick   = pre == PW'(PWM_PRESCALE - 1);

    // pwm_cnt wraps 15->0 by natural overflow of its 4-bit width.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            decay_cnt <= '0;
            pre       <= '0;
            pwm_cnt   <= '0;
        end else begin
            decay_cnt <= decay_tick ? '0 : decay_cnt + 1'b1;
            pre       <= pwm_tick ? '0 : pre + 1'b1;
            pwm_cnt   <= pwm_tick ? pwm_cnt + 1'b1 : pwm_cnt;
        end
    end

    for (genvar i = 0; i < LED_COUNT; i++) begin : g_chan
        kitt_fader_chan #(
            .DECAY_STEP(DECAY_STEP)
        ) u_chan (
            .clk       (CLK),
            .rst_n     (RST_N),
            .fade_en   (FADE_EN),
            .pat       (PAT_IN[i]),
            .decay_tick(decay_tick),
            .pwm_cnt   (pwm_cnt),
            .led       (LED_OUT[i])
        );
    end
endmodule

// File: tb/tb_kitt_fader.sv
// tb_kitt_fader: directed stimulus for kitt_fader, checked every cycle against a cycle-count based model.
module tb_kitt_fader;
    localparam int D = 10;
    localparam int P = 1;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       FADE_EN;
    logic [7:0] PAT_IN;
    logic [7:0] LED_OUT;

    kitt_fader #(
        .DECAY_CYCLES(D),
        .PWM_PRESCALE(P)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .FADE_EN(FADE_EN),
        .PAT_IN (PAT_IN),
        .LED_OUT(LED_OUT)
    );

    always #5 CLK = ~CLK;

    logic [31:0] dut_lv;
    assign dut_lv = {dut.g_chan[7].u_chan.level, dut.g_chan[6].u_chan.level,
                     dut.g_chan[5].u_chan.level, dut.g_chan[4].u_chan.level,
                     dut.g_chan[3].u_chan.level, dut.g_chan[2].u_chan.level,
                     dut.g_chan[1].u_chan.level, dut.g_chan[0].u_chan.level};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: m_n is the number of clock edges since reset released; the decay tick and pwm_cnt
    // are pure functions of that count.
    int         m_level[8];
    logic [7:0] m_led = '0;
    int         m_n   = 0;
    logic       started = 1'b0;

    function automatic logic [31:0] pack_model();
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = 4'(m_level[i]);
        return r;
    endfunction

    always @(posedge CLK) begin
        started <= 1'b1;
        if (!RST_N) begin
            for (int i = 0; i < 8; i++) m_level[i] <= 0;
            m_led <= '0;
            m_n   <= 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                m_led[i]   <= FADE_EN ? (m_level[i] == 15 || m_level[i] > (m_n / P) % 16) : PAT_IN[i];
                m_level[i] <= PAT_IN[i] ? 15 :
                              ((m_n % D) == D - 1) ? ((m_level[i] > 0) ? m_level[i] - 1 : 0) :
                              m_level[i];
            end
            m_n <= m_n + 1;
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            check("model_led", {24'h0, LED_OUT}, {24'h0, m_led});
            check("model_lvl", dut_lv, pack_model());
        end
    end

    initial begin
        int k;
        for (int i = 0; i < 8; i++) m_level[i] = 0;
        RST_N   = 1'b0;
        FADE_EN = 1'b1;
        PAT_IN  = 8'hFF;
        repeat (3) begin
            @(negedge CLK);
            check("rst_led", {24'h0, LED_OUT}, 32'h0);
            check("rst_lvl", dut_lv, 32'h0);
        end
        RST_N  = 1'b1;
        PAT_IN = 8'h00;
        repeat (4) @(negedge CLK);

        // load and latency
        PAT_IN = 8'h01;
        @(negedge CLK);
        check("load_lvl0", {28'h0, dut_lv[3:0]}, 32'hF);
        check("load_model0", 32'(m_level[0]), 32'd15);
        PAT_IN = 8'h00;
        @(negedge CLK);
        check("load_led0", {31'h0, LED_OUT[0]}, 32'h1);
        repeat (150) @(negedge CLK);
        check("dark_led0", {31'h0, LED_OUT[0]}, 32'h0);
        check("dark_lvl0", {28'h0, dut_lv[3:0]}, 32'h0);
        repeat (20) @(negedge CLK);
        check("stay_dark", {24'h0, LED_OUT}, 32'h0);

        // collision: load LED3 on a decay-tick edge while its level is 7
        PAT_IN = 8'h08;
        @(negedge CLK);
        PAT_IN = 8'h00;
        k = 0;
        while (k < 400 && !(m_level[3] == 7 && (m_n % D) == D - 1)) begin
            @(negedge CLK);
            k++;
        end
        check("coll_wait", 32'(k < 400), 32'h1);
        check("coll_pre", {28'h0, dut_lv[15:12]}, 32'h7);
        PAT_IN = 8'h08;
        @(negedge CLK);
        check("coll_lvl3", {28'h0, dut_lv[15:12]}, 32'hF);
        PAT_IN = 8'h00;

        // bypass sweep
        @(negedge CLK);
        FADE_EN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            PAT_IN = 8'h01 << i;
            @(negedge CLK);
            check("bypass", {24'h0, LED_OUT}, 32'h1 << i);
        end
        PAT_IN = 8'h00;
        repeat (2) begin
            @(negedge CLK);
            check("bypass_tail", {24'h0, LED_OUT}, 32'h0);
        end
        FADE_EN = 1'b1;
        repeat (160) @(negedge CLK);
        check("all_dark", dut_lv, 32'h0);

        // reset mid-fade with levels {15,9,3} on LEDs 2,1,0
        PAT_IN = 8'h01;
        @(negedge CLK);
        PAT_IN = 8'h00;
        k = 0;
        while (k < 200 && m_level[0] != 9) begin
            @(negedge CLK);
            k++;
        end
        PAT_IN = 8'h02;
        @(negedge CLK);
        PAT_IN = 8'h00;
        while (k < 200 && m_level[0] != 3) begin
            @(negedge CLK);
            k++;
        end
        check("mid_wait", 32'(k < 200), 32'h1);
        PAT_IN = 8'h04;
        @(negedge CLK);
        PAT_IN = 8'h00;
        check("mid_lvls", {20'h0, dut_lv[11:0]}, 32'hF93);
        RST_N = 1'b0;
        @(negedge CLK);
        check("mid_rst_lvl", dut_lv, 32'h0);
        check("mid_rst_led", {24'h0, LED_OUT}, 32'h0);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_rst_led", {24'h0, LED_OUT}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
